// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave
// Purpose  : Oversampled I2C target with pointer-addressed, auto-incrementing
//            register file exported flat for configuration use.
// Revision : 1.0
// ============================================================================
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         NREGS      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i2c_scl,
    inout  wire                        i2c_sda,
    output logic [8*NREGS-1:0]         reg_data,
    output logic                       wr_strobe,
    output logic [$clog2(NREGS)-1:0]   wr_index,
    output logic                       busy
);

    localparam int c_pw = $clog2(NREGS);

    localparam logic [3:0] c_idle      = 4'd0;
    localparam logic [3:0] c_addr      = 4'd1;
    localparam logic [3:0] c_addr_ack  = 4'd2;
    localparam logic [3:0] c_ptr       = 4'd3;
    localparam logic [3:0] c_ptr_ack   = 4'd4;
    localparam logic [3:0] c_wdata     = 4'd5;
    localparam logic [3:0] c_wdata_ack = 4'd6;
    localparam logic [3:0] c_rdata     = 4'd7;
    localparam logic [3:0] c_rack      = 4'd8;
    localparam logic [3:0] c_ignore    = 4'd9;

    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    logic [3:0]      r_state;
    logic [3:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic [c_pw-1:0] r_ptr;
    logic            r_rw;
    logic [7:0]      r_regs [NREGS];
    logic            r_drv_next;
    logic            r_drv_pend;
    logic            r_sda_low;
    logic            r_busy;
    logic            r_wr_strobe;
    logic [c_pw-1:0] r_wr_index;

    logic            w_scl_rise, w_scl_fall, w_start, w_stop, w_bit, w_last;
    logic [7:0]      w_byte;
    logic [c_pw-1:0] w_ptr_inc;

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_bit      = r_sda_s2;
    assign w_byte     = {r_shift[6:0], w_bit};
    assign w_last     = (r_bitcnt == 4'd7);
    assign w_ptr_inc  = r_ptr + c_pw'(1);

    assign i2c_sda   = r_sda_low ? 1'b0 : 1'bz;
    assign busy      = r_busy;
    assign wr_strobe = r_wr_strobe;
    assign wr_index  = r_wr_index;

    for (genvar k = 0; k < NREGS; k++) begin : g_regs
        assign reg_data[8*k +: 8] = r_regs[k];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= i2c_scl;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= i2c_sda;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_idle;
            r_bitcnt    <= 4'd0;
            r_shift     <= 8'd0;
            r_ptr       <= '0;
            r_rw        <= 1'b0;
            r_drv_next  <= 1'b0;
            r_drv_pend  <= 1'b0;
            r_sda_low   <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_index  <= '0;
            for (int k = 0; k < NREGS; k++) r_regs[k] <= 8'd0;
        end else begin
            r_wr_strobe <= 1'b0;
            r_drv_pend  <= 1'b0;
            // SDA changes are decided on the SCL fall but applied one cycle later
            if (r_drv_pend) r_sda_low <= r_drv_next;

            if (w_start) begin
                r_state   <= c_addr;
                r_bitcnt  <= 4'd0;
                r_sda_low <= 1'b0;
            end else if (w_stop) begin
                r_state   <= c_idle;
                r_bitcnt  <= 4'd0;
                r_sda_low <= 1'b0;
                r_busy    <= 1'b0;
            end else if (w_scl_rise) begin
                case (r_state)
                    c_addr: begin
                        r_shift <= w_byte;
                        if (w_last) begin
                            r_bitcnt <= 4'd0;
                            if (w_byte[7:1] == SLAVE_ADDR) begin
                                r_state <= c_addr_ack;
                                r_rw    <= w_byte[0];
                                r_busy  <= 1'b1;
                            end else begin
                                r_state <= c_ignore;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end
                    c_ptr: begin
                        r_shift <= w_byte;
                        if (w_last) begin
                            r_ptr    <= w_byte[c_pw-1:0];
                            r_state  <= c_ptr_ack;
                            r_bitcnt <= 4'd0;
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end
                    c_wdata: begin
                        r_shift <= w_byte;
                        if (w_last) begin
                            r_regs[r_ptr] <= w_byte;
                            r_wr_strobe   <= 1'b1;
                            r_wr_index    <= r_ptr;
                            r_ptr         <= w_ptr_inc;
                            r_state       <= c_wdata_ack;
                            r_bitcnt      <= 4'd0;
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end
                    c_rdata: r_bitcnt <= r_bitcnt + 4'd1;
                    c_rack: begin
                        if (!w_bit) begin
                            r_ptr    <= w_ptr_inc;
                            r_shift  <= r_regs[w_ptr_inc];
                            r_state  <= c_rdata;
                            r_bitcnt <= 4'd0;
                        end else begin
                            r_state <= c_ignore;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end else if (w_scl_fall) begin
                case (r_state)
                    // ACK states: first fall starts the ACK, second fall ends it
                    c_addr_ack, c_ptr_ack, c_wdata_ack: begin
                        r_drv_pend <= 1'b1;
                        if (r_bitcnt == 4'd0) begin
                            r_drv_next <= 1'b1;
                            r_bitcnt   <= 4'd1;
                        end else begin
                            r_bitcnt <= 4'd0;
                            if (r_state == c_addr_ack && r_rw) begin
                                r_state    <= c_rdata;
                                r_shift    <= r_regs[r_ptr];
                                r_drv_next <= ~r_regs[r_ptr][7];
                            end else begin
                                r_drv_next <= 1'b0;
                                r_state    <= (r_state == c_addr_ack) ? c_ptr : c_wdata;
                            end
                        end
                    end
                    c_rdata: begin
                        r_drv_pend <= 1'b1;
                        if (r_bitcnt == 4'd8) begin
                            r_drv_next <= 1'b0;
                            r_state    <= c_rack;
                            r_bitcnt   <= 4'd0;
                        end else if (r_bitcnt == 4'd0) begin
                            r_drv_next <= ~r_shift[7];
                        end else begin
                            r_shift    <= {r_shift[6:0], 1'b0};
                            r_drv_next <= ~r_shift[6];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave
// Purpose  : Directed bus-level bench for i2c_slave with hand-computed results.
// Revision : 1.0
// ============================================================================
module tb_i2c_slave;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        scl   = 1'b1;
    logic        m_low = 1'b0;
    wire         sda;
    logic [31:0] reg_data;
    logic        wr_strobe;
    logic [1:0]  wr_index;
    logic        busy;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave #(.SLAVE_ADDR(7'h50), .NREGS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .i2c_scl   (scl),
        .i2c_sda   (sda),
        .reg_data  (reg_data),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         n_pass  = 0;
    int         n_total = 0;
    int         strobes = 0;
    int         slave_low = 0;
    logic [1:0] idx_q[$];

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobes++;
            idx_q.push_back(wr_index);
        end
        if (!m_low && sda === 1'b0) slave_low++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic b);
        cyc(5); m_low = ~b;
        cyc(5); scl = 1'b1;
        cyc(10); scl = 1'b0;
    endtask

    task automatic bit_in(output logic b);
        cyc(5); m_low = 1'b0;
        cyc(5); scl = 1'b1;
        cyc(5); b = sda;
        cyc(5); scl = 1'b0;
    endtask

    task automatic start_cond();
        cyc(5); m_low = 1'b0;
        cyc(5); scl = 1'b1;
        cyc(10); m_low = 1'b1;
        cyc(10); scl = 1'b0;
    endtask

    task automatic stop_cond();
        cyc(5); m_low = 1'b1;
        cyc(5); scl = 1'b1;
        cyc(10); m_low = 1'b0;
        cyc(10);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(b);
        ack = ~b;
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
        bit_out(nack);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cyc(5);
        n_total++; if (sda !== 1'b1) $display("FAIL rst_sda: got %b want 1", sda); else n_pass++;
        n_total++; if (reg_data !== 32'h0) $display("FAIL rst_regs: got %h want 0", reg_data); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (wr_strobe !== 1'b0) $display("FAIL rst_strobe: got %b want 0", wr_strobe); else n_pass++;
        n_total++; if (wr_index !== 2'd0) $display("FAIL rst_index: got %0d want 0", wr_index); else n_pass++;
        reset = 1'b1;
        cyc(5);
    endtask

    task automatic test_write_burst();
        logic       a;
        int         acks = 0;
        int         s0 = strobes;
        logic [7:0] bytes [5] = '{8'hA0, 8'h01, 8'h11, 8'h22, 8'h33};
        logic [1:0] got;
        idx_q.delete();
        start_cond();
        for (int i = 0; i < 5; i++) begin
            send_byte(bytes[i], a);
            if (a) acks++;
            if (i == 0) begin
                n_total++; if (busy !== 1'b1) $display("FAIL wr_busy_hi: got %b want 1", busy); else n_pass++;
            end
        end
        stop_cond();
        n_total++; if (acks != 5) $display("FAIL wr_acks: got %0d want 5", acks); else n_pass++;
        n_total++; if (strobes - s0 != 3) $display("FAIL wr_strobes: got %0d want 3", strobes - s0); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            got = (i < idx_q.size()) ? idx_q[i] : 2'bxx;
            n_total++; if (got !== 2'(i + 1)) $display("FAIL wr_index%0d: got %0d want %0d", i, got, i + 1); else n_pass++;
        end
        n_total++; if (reg_data !== 32'h33221100) $display("FAIL wr_regs: got %h want 33221100", reg_data); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL wr_busy_lo: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid_ack();
        logic [7:0] addr = 8'hA0;
        start_cond();
        for (int i = 7; i >= 0; i--) bit_out(addr[i]);
        cyc(5); m_low = 1'b0;
        cyc(3);
        n_total++; if (sda !== 1'b0) $display("FAIL mid_ack_low: got %b want 0", sda); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL mid_busy_hi: got %b want 1", busy); else n_pass++;
        reset = 1'b0;
        cyc(10);
        n_total++; if (sda !== 1'b1) $display("FAIL mid_rst_sda: got %b want 1", sda); else n_pass++;
        n_total++; if (reg_data !== 32'h0) $display("FAIL mid_rst_regs: got %h want 0", reg_data); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (wr_strobe !== 1'b0) $display("FAIL mid_rst_strobe: got %b want 0", wr_strobe); else n_pass++;
        reset = 1'b1;
        cyc(2);
        stop_cond();
    endtask

    task automatic test_wrap();
        logic a;
        start_cond();
        send_byte(8'hA0, a); send_byte(8'h03, a); send_byte(8'hAA, a); send_byte(8'hBB, a);
        stop_cond();
        n_total++; if (reg_data !== 32'hAA0000BB) $display("FAIL wrap_regs: got %h want AA0000BB", reg_data); else n_pass++;
        start_cond();
        send_byte(8'hA0, a); send_byte(8'h07, a); send_byte(8'hCC, a);
        stop_cond();
        n_total++; if (reg_data !== 32'hCC0000BB) $display("FAIL ptr_mask: got %h want CC0000BB", reg_data); else n_pass++;
    endtask

    task automatic test_combined_read();
        logic       a;
        int         acks = 0;
        logic [7:0] d [3];
        logic [7:0] exp_d [3] = '{8'h33, 8'h44, 8'h11};
        start_cond();
        send_byte(8'hA0, a); send_byte(8'h00, a);
        send_byte(8'h11, a); send_byte(8'h22, a); send_byte(8'h33, a); send_byte(8'h44, a);
        stop_cond();
        n_total++; if (reg_data !== 32'h44332211) $display("FAIL preload: got %h want 44332211", reg_data); else n_pass++;
        start_cond();
        send_byte(8'hA0, a); if (a) acks++;
        send_byte(8'h02, a); if (a) acks++;
        start_cond();
        send_byte(8'hA1, a); if (a) acks++;
        recv_byte(d[0], 1'b0);
        recv_byte(d[1], 1'b0);
        recv_byte(d[2], 1'b1);
        n_total++; if (acks != 3) $display("FAIL rd_acks: got %0d want 3", acks); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++; if (d[i] !== exp_d[i]) $display("FAIL rd_byte%0d: got %h want %h", i, d[i], exp_d[i]); else n_pass++;
        end
        cyc(10);
        n_total++; if (sda !== 1'b1) $display("FAIL rd_release: got %b want 1", sda); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rd_nack_busy: got %b want 0", busy); else n_pass++;
        stop_cond();
        n_total++; if (busy !== 1'b0) $display("FAIL rd_stop_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_addr_mismatch();
        logic a;
        int   acks = 0;
        int   s0 = strobes;
        int   l0 = slave_low;
        start_cond();
        send_byte(8'hA2, a); if (a) acks++;
        n_total++; if (busy !== 1'b0) $display("FAIL mm_busy: got %b want 0", busy); else n_pass++;
        send_byte(8'h00, a); if (a) acks++;
        send_byte(8'h55, a); if (a) acks++;
        stop_cond();
        n_total++; if (acks != 0) $display("FAIL mm_acks: got %0d want 0", acks); else n_pass++;
        n_total++; if (slave_low != l0) $display("FAIL mm_sda_low: got %0d want %0d", slave_low, l0); else n_pass++;
        n_total++; if (strobes != s0) $display("FAIL mm_strobes: got %0d want %0d", strobes, s0); else n_pass++;
        n_total++; if (reg_data !== 32'h44332211) $display("FAIL mm_regs: got %h want 44332211", reg_data); else n_pass++;
    endtask

    task automatic test_abort();
        logic       a;
        logic [7:0] d;
        int         s0 = strobes;
        start_cond();
        send_byte(8'hA0, a); send_byte(8'h01, a);
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b0); bit_out(1'b1);
        stop_cond();
        n_total++; if (strobes != s0) $display("FAIL ab_strobes: got %0d want %0d", strobes, s0); else n_pass++;
        n_total++; if (reg_data !== 32'h44332211) $display("FAIL ab_regs: got %h want 44332211", reg_data); else n_pass++;
        start_cond();
        send_byte(8'hA0, a);
        n_total++; if (a !== 1'b1) $display("FAIL ab_addr_ack: got %b want 1", a); else n_pass++;
        stop_cond();
        start_cond();
        send_byte(8'hA1, a);
        n_total++; if (a !== 1'b1) $display("FAIL ab_rd_ack: got %b want 1", a); else n_pass++;
        recv_byte(d, 1'b1);
        stop_cond();
        n_total++; if (d !== 8'h22) $display("FAIL ab_ptr_read: got %h want 22", d); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_reset_mid_ack();
        test_wrap();
        test_combined_read();
        test_addr_mismatch();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
